// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, mem_command
// bit positions, FSM state encoding and small decode helpers.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int CMD_ACCESS = 0;
  localparam int CMD_WRITE  = 1;
  localparam int CMD_F3_LO  = 2;
  localparam int CMD_F3_HI  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TRAP = 2'd2
  } state_t;

  // funct3 values with no defined load/store width never reach the bus
  function automatic logic f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

  // Halfword accesses need a[0]=0, word accesses need a[1:0]=0
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] alo);
    logic mis;
    mis = 1'b0;
    case (f3)
      LH, LHU: mis = alo[0];
      LW:      mis = (alo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it according to funct3. Purely combinational so
// a future cache refill path can reuse it.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
      LW:      data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Runs loads/stores over a req/ready bus,
// steers store lanes, formats load data and stalls upstream while busy.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses
// into a one-cycle trap instead of silently using the low address bits.
//
//   state | meaning
//   IDLE  | accept a new instruction from execute
//   WAIT  | bus request outstanding, waiting for mem_ready or timeout
//   TRAP  | one-cycle misaligned-access trap pulse (macro build only)
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stop,
  input  logic            bubble,
  input  logic [4:0]      in_mem_command,
  input  logic [4:0]      in_reg_d,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] in_mem_write_data,
  input  logic [XLEN-1:0] in_now_pc,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_busy,
  output logic [4:0]      out_reg_d,
  output logic [XLEN-1:0] out_wb_data,
  output logic [XLEN-1:0] out_now_pc,
  output logic            out_trap,
  output logic [XLEN-1:0] out_trap_addr
);

  localparam int TMR_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (BUS_TIMEOUT > 0) ? TMR_W'(BUS_TIMEOUT - 1) : '0;

  state_t state_q, state_d;

  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [4:0]      reg_d_q, reg_d_d;
  logic [XLEN-1:0] wb_q, wb_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      lat_rd_q, lat_rd_d;
  logic [2:0]      lat_f3_q, lat_f3_d;
  logic [1:0]      lat_alo_q, lat_alo_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [2:0]      cmd_f3;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] load_data;
  logic            timeout;

  assign cmd_f3  = in_mem_command[CMD_F3_HI:CMD_F3_LO];
  assign timeout = (BUS_TIMEOUT > 0) && (timer_q == '0);

`ifdef MEM_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;

  assign out_trap      = trap_q;
  assign out_trap_addr = trap_addr_q;
`else
  assign out_trap      = 1'b0;
  assign out_trap_addr = '0;
`endif

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (lat_alo_q),
    .funct3  (lat_f3_q),
    .data    (load_data)
  );

  // Store lane steering from the incoming address and funct3
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = in_mem_write_data;
    case (cmd_f3)
      SB: begin
        st_strb  = 4'b0001 << alu_out[1:0];
        st_wdata = XLEN'({4{in_mem_write_data[7:0]}});
      end
      SH: begin
        st_strb  = 4'b0011 << {alu_out[1], 1'b0};
        st_wdata = XLEN'({2{in_mem_write_data[15:0]}});
      end
      SW: begin
        st_strb  = 4'b1111;
        st_wdata = in_mem_write_data;
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = in_mem_write_data;
      end
    endcase
  end

  // Next-state and next-register values; everything holds unless changed
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    reg_d_d   = reg_d_q;
    wb_d      = wb_q;
    pc_d      = pc_q;
    lat_rd_d  = lat_rd_q;
    lat_f3_d  = lat_f3_q;
    lat_alo_d = lat_alo_q;
    timer_d   = timer_q;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
`endif

    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (bubble) begin
          reg_d_d = '0;
          wb_d    = '0;
          pc_d    = in_now_pc;
        end else if (!in_mem_command[CMD_ACCESS]) begin
          reg_d_d = in_reg_d;
          wb_d    = alu_out;
          pc_d    = in_now_pc;
        end else if (!f3_legal(cmd_f3)) begin
          reg_d_d = '0;
          pc_d    = in_now_pc;
`ifdef MEM_MISALIGN_TRAP_EN
        end else if (is_misaligned(cmd_f3, alu_out[1:0])) begin
          state_d     = TRAP;
          reg_d_d     = '0;
          pc_d        = in_now_pc;
          trap_d      = 1'b1;
          trap_addr_d = alu_out;
`endif
        end else begin
          state_d   = WAIT;
          req_d     = 1'b1;
          we_d      = in_mem_command[CMD_WRITE];
          addr_d    = {alu_out[XLEN-1:2], 2'b00};
          wdata_d   = st_wdata;
          wstrb_d   = st_strb;
          lat_rd_d  = in_reg_d;
          lat_f3_d  = cmd_f3;
          lat_alo_d = alu_out[1:0];
          reg_d_d   = '0;
          pc_d      = in_now_pc;
          timer_d   = TMR_LOAD;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (we_q) begin
            reg_d_d = '0;
          end else begin
            reg_d_d = lat_rd_q;
            wb_d    = load_data;
          end
        end else if (timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          reg_d_d = '0;
        end else begin
          reg_d_d = '0;
          timer_d = timer_q - TMR_W'(1);
        end
      end
      TRAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Upstream stalls while a transaction is open or about to open, and
  // for the trap cycle
  assign mem_busy = ((state_q == WAIT) && !mem_ready) || (state_d == WAIT) ||
                    (state_q == TRAP);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus, writeback and latched-request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      reg_d_q   <= '0;
      wb_q      <= '0;
      pc_q      <= '0;
      lat_rd_q  <= '0;
      lat_f3_q  <= '0;
      lat_alo_q <= '0;
      timer_q   <= '0;
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      reg_d_q   <= reg_d_d;
      wb_q      <= wb_d;
      pc_q      <= pc_d;
      lat_rd_q  <= lat_rd_d;
      lat_f3_q  <= lat_f3_d;
      lat_alo_q <= lat_alo_d;
      timer_q   <= timer_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Trap pulse and faulting address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end
`endif

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign out_reg_d   = reg_d_q;
  assign out_wb_data = wb_q;
  assign out_now_pc  = pc_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a writeback scoreboard.
// Covers the misaligned-trap path when MEM_MISALIGN_TRAP_EN is defined.
module tb_mem_access;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            stop;
  logic            bubble;
  logic [4:0]      in_mem_command;
  logic [4:0]      in_reg_d;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] in_mem_write_data;
  logic [XLEN-1:0] in_now_pc;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_busy;
  logic [4:0]      out_reg_d;
  logic [XLEN-1:0] out_wb_data;
  logic [XLEN-1:0] out_now_pc;
  logic            out_trap;
  logic [XLEN-1:0] out_trap_addr;

  mem_access #(.XLEN(XLEN), .BUS_TIMEOUT(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stop              (stop),
    .bubble            (bubble),
    .in_mem_command    (in_mem_command),
    .in_reg_d          (in_reg_d),
    .alu_out           (alu_out),
    .in_mem_write_data (in_mem_write_data),
    .in_now_pc         (in_now_pc),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_ready         (mem_ready),
    .mem_rdata         (mem_rdata),
    .mem_busy          (mem_busy),
    .out_reg_d         (out_reg_d),
    .out_wb_data       (out_wb_data),
    .out_now_pc        (out_now_pc),
    .out_trap          (out_trap),
    .out_trap_addr     (out_trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        chk_wb;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    in_mem_command    = 5'd0;
    in_reg_d          = 5'd0;
    alu_out           = '0;
    in_mem_write_data = '0;
    in_now_pc         = '0;
  endtask

  task automatic issue(input logic [4:0] cmd, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc);
    in_mem_command    = cmd;
    in_reg_d          = rd;
    alu_out           = a;
    in_mem_write_data = wd;
    in_now_pc         = pc;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] wb, input logic chk_wb,
                      input logic [31:0] pc);
    exp_t e;
    e.rd = rd; e.wb = wb; e.chk_wb = chk_wb; e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rd"}, 32'(out_reg_d), 32'(e.rd));
      if (e.chk_wb) chk({tag, "_wb"}, out_wb_data, e.wb);
      chk({tag, "_pc"}, out_now_pc, e.pc);
    end
  endtask

  // Called with the access already driven, at posedge+1 of its IDLE cycle.
  task automatic do_access(input string tag, input int ready_at, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata, input logic stop_in_wait);
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    if (mem_busy) busy_n++;
    for (int c = 1; c <= ready_at; c++) begin
      step();
      if (stop_in_wait) stop = 1'b1;
      if (c == ready_at) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_addr"}, mem_addr, e_addr);
      if (c == 1) begin
        chk({tag, "_we"}, 32'(mem_we), 32'(e_we));
        if (e_we) begin
          chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
          chk({tag, "_wdata"}, mem_wdata, e_wdata);
        end
      end
      @(negedge clk);
      if (mem_busy) busy_n++;
    end
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    stop      = 1'b0;
    nop();
    chk({tag, "_req_done"}, 32'(mem_req), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(ready_at));
    sb_pop(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    stop      = 1'b0;
    bubble    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    nop();
    step();
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_rd", 32'(out_reg_d), 32'd0);
    chk("rst_wb", out_wb_data, 32'd0);
    chk("rst_pc", out_now_pc, 32'd0);
    chk("rst_trap", 32'(out_trap), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    rst_n = 1'b1;

    // Plain ALU result passes through with one cycle latency
    issue(5'b00000, 5'd5, 32'h1234, 32'h0, 32'h40);
    push(5'd5, 32'h1234, 1'b1, 32'h40);
    step();
    chk("alu_req", 32'(mem_req), 32'd0);
    sb_pop("alu");

    // stop holds outputs even with bubble asserted
    issue(5'b00000, 5'd4, 32'h77, 32'h0, 32'h84);
    push(5'd4, 32'h77, 1'b1, 32'h84);
    step();
    sb_pop("alu2");
    issue(5'b00000, 5'd6, 32'h55, 32'h0, 32'h90);
    stop   = 1'b1;
    bubble = 1'b1;
    push(5'd4, 32'h77, 1'b1, 32'h84);
    step();
    sb_pop("stop");
    stop = 1'b0;
    push(5'd0, 32'h0, 1'b1, 32'h90);
    step();
    sb_pop("bubble");
    bubble = 1'b0;

    // lb, byte 3, sign-extended, ready on third WAIT cycle
    issue(5'b00001, 5'd7, 32'h103, 32'h0, 32'h44);
    push(5'd7, 32'hFFFF_FF80, 1'b1, 32'h44);
    do_access("lb", 3, 32'h80FF_FFFF, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);

    // sh to upper half
    issue(5'b00111, 5'd9, 32'h202, 32'h0000_ABCD, 32'h48);
    push(5'd0, 32'h0, 1'b0, 32'h48);
    do_access("sh", 2, 32'h0, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0);

    // lhu with stop during WAIT
    issue(5'b10101, 5'd10, 32'h002, 32'h0, 32'h4C);
    push(5'd10, 32'h0000_F00D, 1'b1, 32'h4C);
    do_access("lhu", 2, 32'hF00D_1234, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1);

    // sb lane 1
    issue(5'b00011, 5'd1, 32'h001, 32'h1234_565A, 32'h50);
    push(5'd0, 32'h0, 1'b0, 32'h50);
    do_access("sb", 1, 32'h0, 32'h0, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b0);

    // sw, minimum latency
    issue(5'b01011, 5'd2, 32'h300, 32'hDEAD_BEEF, 32'h54);
    push(5'd0, 32'h0, 1'b0, 32'h54);
    do_access("sw", 1, 32'h0, 32'h300, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0);

    // lh, lower half, sign-extended
    issue(5'b00101, 5'd3, 32'h000, 32'h0, 32'h58);
    push(5'd3, 32'hFFFF_8001, 1'b1, 32'h58);
    do_access("lh", 1, 32'h1234_8001, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0);

    // Illegal funct3: no bus transaction
    issue(5'b01101, 5'd8, 32'h400, 32'h0, 32'h94);
    push(5'd0, 32'h0, 1'b0, 32'h94);
    @(negedge clk);
    chk("ill_busy", 32'(mem_busy), 32'd0);
    step();
    nop();
    chk("ill_req", 32'(mem_req), 32'd0);
    sb_pop("ill");

    // Timeout after 4 WAIT cycles with no ready
    issue(5'b01001, 5'd10, 32'h10, 32'h0, 32'hA0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("tmo_req_wait", 32'(mem_req), 32'd1);
    end
    step();
    nop();
    chk("tmo_req", 32'(mem_req), 32'd0);
    chk("tmo_rd", 32'(out_reg_d), 32'd0);
    @(negedge clk);
    chk("tmo_busy", 32'(mem_busy), 32'd0);

    // Reset in the middle of WAIT
    issue(5'b01001, 5'd11, 32'h20, 32'h0, 32'hB0);
    step();
    chk("rstw_req_wait", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    nop();
    step();
    chk("rstw_req", 32'(mem_req), 32'd0);
    chk("rstw_we", 32'(mem_we), 32'd0);
    chk("rstw_addr", mem_addr, 32'd0);
    chk("rstw_rd", 32'(out_reg_d), 32'd0);
    chk("rstw_wb", out_wb_data, 32'd0);
    chk("rstw_pc", out_now_pc, 32'd0);
    rst_n = 1'b1;

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned lw traps for one cycle without touching the bus
    issue(5'b01001, 5'd12, 32'h6, 32'h0, 32'hC0);
    push(5'd0, 32'h0, 1'b0, 32'hC0);
    @(negedge clk);
    chk("mis_busy_idle", 32'(mem_busy), 32'd0);
    step();
    nop();
    chk("mis_trap", 32'(out_trap), 32'd1);
    chk("mis_trap_addr", out_trap_addr, 32'h6);
    chk("mis_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("mis_busy_trap", 32'(mem_busy), 32'd1);
    step();
    chk("mis_trap_end", 32'(out_trap), 32'd0);
    chk("mis_req_end", 32'(mem_req), 32'd0);
    sb_pop("mis");
`else
    // Misaligned lw silently aligns to the containing word
    issue(5'b01001, 5'd12, 32'h6, 32'h0, 32'hC0);
    push(5'd12, 32'hCAFE_BABE, 1'b1, 32'hC0);
    do_access("lw_al", 2, 32'hCAFE_BABE, 32'h4, 1'b0, 4'b0000, 32'h0, 1'b0);
    chk("lw_al_trap", 32'(out_trap), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage directly downstream of the execute stage.
- Consumes the execute outputs: ALU result/address, store data, mem command, rd and PC.
- Performs data-bus loads and stores through a req/ready handshake, with byte-lane steering and load sign/zero extension.
- Presents registered results to writeback and stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width.
- BUS_TIMEOUT, 0, cycles in WAIT before aborting the transaction; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- stop  in  1  freeze stage outputs (pipeline pause).
- bubble  in  1  inject NOP into writeback.
- in_mem_command  in  5  [0] access, [1] 1=write/0=read, [4:2] funct3.
- in_reg_d  in  5  destination register.
- alu_out  in  XLEN  result, or effective address when accessing memory.
- in_mem_write_data  in  XLEN  store data (rs2).
- in_now_pc  in  XLEN  instruction PC.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  XLEN  word-aligned bus address.
- mem_wdata  out  XLEN  lane-steered store data.
- mem_wstrb  out  4  byte strobes.
- mem_ready  in  1  bus completion.
- mem_rdata  in  XLEN  bus read word.
- mem_busy  out  1  stall request to IF/ID/EX.
- out_reg_d  out  5  writeback rd (0 = no write).
- out_wb_data  out  XLEN  writeback data.
- out_now_pc  out  XLEN  PC passed to writeback.
- out_trap  out  1  misaligned-access trap pulse.
- out_trap_addr  out  XLEN  faulting address.

Behaviour:
- Reset: at a posedge with rst_n=0, FSM goes to IDLE and every output register goes to 0, including mem_req and out_trap. A reset during WAIT drops mem_req at that edge; the bus tolerates the abandoned request.
- States: IDLE, WAIT, TRAP. IDLE→WAIT on a legal access; WAIT→IDLE on mem_ready or timeout; IDLE→TRAP on a misaligned access (macro only); TRAP→IDLE unconditionally after 1 cycle.
- IDLE with stop=1: all registers hold and no access starts; stop has priority over bubble.
- IDLE with bubble=1: out_reg_d and out_wb_data are zeroed, out_now_pc<=in_now_pc, no access.
- IDLE, no access (in_mem_command[0]=0): out_wb_data<=alu_out, out_reg_d<=in_reg_d, out_now_pc<=in_now_pc. Latency 1 cycle.
- IDLE, access: the stage latches addr, write data, funct3, rd and pc. mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb are registered and valid from the first WAIT cycle, then held stable until mem_ready. out_reg_d<=0 during WAIT.
- mem_busy = (state==WAIT & ~mem_ready) | (next state is WAIT). Upstream holds while it is high.
- WAIT: stop and bubble are ignored; the transaction always completes. On mem_ready, mem_req drops in the same edge.
  - Load: out_wb_data<=formatted read data, out_reg_d<=latched rd.
  - Store: out_reg_d<=0.
  - Minimum access latency is 2 cycles with mem_ready in the first WAIT cycle.
- Store steering:
  - sb (000): wstrb=0001<<a[1:0], wdata=byte replicated x4.
  - sh (001): wstrb=0011<<{a[1],0}, wdata=half replicated x2.
  - sw (010): wstrb=1111.
- Load formatting:
  - lb (000) / lbu (100): byte at a[1:0], sign- or zero-extended.
  - lh (001) / lhu (101): half at a[1], sign- or zero-extended.
  - lw (010): full word.
- Illegal funct3 (011, 110, 111): no bus transaction, out_reg_d<=0.
- mem_addr = {a[XLEN-1:2], 2'b00} always.
- Timeout: if BUS_TIMEOUT>0 and WAIT lasts BUS_TIMEOUT cycles, mem_req drops, out_reg_d<=0 and the FSM returns to IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Misaligned means a[0]=1 for lh/lhu/sh, or a[1:0]≠0 for lw/sw.
- Defined: a misaligned access goes to TRAP. There is no bus transaction, out_trap=1 for exactly 1 cycle, out_trap_addr=a, out_reg_d=0, and mem_busy is high for that cycle.
- Undefined: the low address bits select lanes as above (word access silently aligned). out_trap and out_trap_addr are tied to 0.

Decomposition:
- Package mem_pkg: funct3 constants (LB..SW), mem_command bit indices, state enum (IDLE/WAIT/TRAP).
- Sub-module load_align: combinational rdata, a[1:0], funct3 → extended load data. Shared with any future cache refill path.

Test Plan:
- Non-access: alu_out=0x1234, rd=5 → next cycle out_wb_data=0x1234, out_reg_d=5, mem_req=0.
- lb: a=0x103, rdata=0x80FF_FFFF, ready on 3rd WAIT cycle → mem_addr=0x100, mem_busy high 3 cycles, out_wb_data=0xFFFF_FF80.
- sh: a=0x202, data=0x0000_ABCD → mem_wstrb=1100, mem_wdata=0xABCD_ABCD, mem_we=1, out_reg_d=0.
- lhu: a=0x002, rdata=0xF00D_1234 → 0x0000_F00D; stop asserted during WAIT → result still written.
- Reset mid-WAIT: rst_n=0 → mem_req=0 and all outputs 0 next edge; BUS_TIMEOUT=4 with no ready → abort after 4 cycles, out_reg_d=0.
- MEM_MISALIGN_TRAP_EN: lw a=0x0006 → no mem_req, out_trap pulse 1 cycle, out_trap_addr=0x0006.
